// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3-encoded opcodes and decode helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    function automatic logic is_div(muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic wants_high(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide engine (slave).
interface ex_muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             start;
    muldiv_op_t       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start, op, a, b, tag_in, flush,
        input  busy, stall_req, done, result, tag_out
    );

    modport slave (
        input  start, op, a, b, tag_in, flush,
        output busy, stall_req, done, result, tag_out
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on the {hi, lo} pair.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shl  = {hi, lo[XLEN-1]};
        diff = shl - {1'b0, opnd};
        if (is_div) begin
            // Remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
            if (!diff[XLEN]) begin
                hi_nx = diff[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = shl[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine beside the EX-stage ALU; stalls the pipe while iterating.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input logic               clk,
    input logic               rst_n,
    ex_muldiv_unit_if.slave   io
);
    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state, state_nx;
    muldiv_op_t       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             sign_a_q, sign_b_q;
    logic [XLEN-1:0]  hi_q, lo_q, opnd_q, result_q;
    logic [CNT_W-1:0] cnt;

    logic             sa, sb, div_zero, ovf, fast;
    logic [XLEN-1:0]  abs_a, abs_b, fast_res;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]  quot_fix, rem_fix, fix_res;
    logic             res_neg, accept;

    logic [XLEN-1:0]  hi_ch [UNROLL+1];
    logic [XLEN-1:0]  lo_ch [UNROLL+1];

    assign hi_ch[0] = hi_q;
    assign lo_ch[0] = lo_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (is_div(op_q)),
            .hi     (hi_ch[g]),
            .lo     (lo_ch[g]),
            .opnd   (opnd_q),
            .hi_nx  (hi_ch[g+1]),
            .lo_nx  (lo_ch[g+1])
        );
    end

    // Operand capture and the single-edge fast path for divide-by-zero and signed overflow.
    always_comb begin
        sa       = is_signed_a(io.op) & io.a[XLEN-1];
        sb       = is_signed_b(io.op) & io.b[XLEN-1];
        abs_a    = sa ? -io.a : io.a;
        abs_b    = sb ? -io.b : io.b;
        div_zero = (io.b == '0);
        ovf      = (io.op inside {OP_DIV, OP_REM}) && (io.a == MIN_NEG) && (io.b == '1);
        fast     = is_div(io.op) && (div_zero || ovf);
        if (div_zero) fast_res = (io.op inside {OP_REM, OP_REMU}) ? io.a : '1;
        else          fast_res = (io.op inside {OP_REM, OP_REMU}) ? '0 : io.a;
        accept   = (state == S_IDLE) && io.start && !io.flush;
    end

    // Sign correction and high/low select on the finished magnitudes.
    always_comb begin
        res_neg  = sign_a_q ^ sign_b_q;
        prod_mag = {hi_q, lo_q};
        prod_fix = res_neg ? -prod_mag : prod_mag;
        quot_fix = res_neg ? -lo_q : lo_q;
        rem_fix  = sign_a_q ? -hi_q : hi_q;
        if (is_div(op_q))
            fix_res = (op_q inside {OP_REM, OP_REMU}) ? rem_fix : quot_fix;
        else
            fix_res = wants_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        io.busy      = (state != S_IDLE);
        io.stall_req = accept || (state == S_CALC) || (state == S_FIX);
        io.done      = (state == S_DONE);
        io.result    = result_q;
        io.tag_out   = tag_q;
        if (io.flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (io.start) state_nx = fast ? S_DONE : S_CALC;
                S_CALC:  if (cnt == '0) state_nx = S_FIX;
                S_FIX:   state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            tag_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q     <= io.op;
                    tag_q    <= io.tag_in;
                    sign_a_q <= sa;
                    sign_b_q <= sb;
                    hi_q     <= '0;
                    lo_q     <= abs_a;
                    opnd_q   <= abs_b;
                    cnt      <= CNT_W'(N - 1);
                    if (fast) result_q <= fast_res;
                end
                S_CALC: begin
                    hi_q <= hi_ch[UNROLL];
                    lo_q <= lo_ch[UNROLL];
                    cnt  <= cnt - 1'b1;
                end
                S_FIX:   result_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: vector table plus scoreboard on UNROLL=1 and UNROLL=4 instances.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus1 ();
    ex_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus4 ();

    ex_muldiv_unit #(.XLEN(XLEN), .UNROLL(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(bus1.slave));
    ex_muldiv_unit #(.XLEN(XLEN), .UNROLL(4), .TAG_W(TAG_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .io(bus4.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t sb1[$];
    exp_t sb4[$];
    exp_t e1, e4;
    vec_t vecs[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus1.done) begin
            if (sb1.size() == 0) check("u1_spurious_done", bus1.done, 0);
            else begin
                e1 = sb1.pop_front();
                check("u1_result", bus1.result, e1.res);
                check("u1_tag", bus1.tag_out, e1.tag);
            end
        end
        if (rst_n && bus4.done) begin
            if (sb4.size() == 0) check("u4_spurious_done", bus4.done, 0);
            else begin
                e4 = sb4.pop_front();
                check("u4_result", bus4.result, e4.res);
                check("u4_tag", bus4.tag_out, e4.tag);
            end
        end
    end

    task automatic issue1(muldiv_op_t op, logic [31:0] a, logic [31:0] b, logic [4:0] tag,
                          logic [31:0] exp, int lat, string name);
        int n = 0;
        int stall_bad = 0;
        logic seen = 1'b0;
        bus1.start = 1'b1; bus1.op = op; bus1.a = a; bus1.b = b; bus1.tag_in = tag;
        sb1.push_back('{exp, tag});
        #1 check({name, "_stall0"}, bus1.stall_req, 1);
        while (!seen && n < 100) begin
            @(posedge clk); n++;
            #1;
            if (n == 1) begin
                bus1.start = 1'b0;
                bus1.op = muldiv_op_t'($urandom_range(0, 7));
                bus1.a = $urandom; bus1.b = $urandom; bus1.tag_in = 5'($urandom);
            end
            @(negedge clk);
            if (bus1.done) seen = 1'b1;
            else if (!bus1.stall_req) stall_bad++;
        end
        check({name, "_latency"}, n, lat);
        check({name, "_stall_in_done"}, bus1.stall_req, 0);
        check({name, "_stall_busy"}, stall_bad, 0);
        @(negedge clk);
        check({name, "_pulse_end"}, {bus1.done, bus1.busy}, 0);
    endtask

    task automatic issue4(muldiv_op_t op, logic [31:0] a, logic [31:0] b, logic [4:0] tag,
                          logic [31:0] exp, int lat, string name);
        int n = 0;
        logic seen = 1'b0;
        bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b; bus4.tag_in = tag;
        sb4.push_back('{exp, tag});
        while (!seen && n < 60) begin
            @(posedge clk); n++;
            #1 if (n == 1) begin bus4.start = 1'b0; bus4.a = $urandom; bus4.b = $urandom; end
            @(negedge clk);
            seen = bus4.done;
        end
        check({name, "_latency"}, n, lat);
        @(negedge clk);
    endtask

    task automatic run_b2b();
        logic [31:0] da[4] = '{32'd1000, 32'hFFFF_FFFF, 32'd12345, 32'd3};
        logic [31:0] db[4] = '{32'd7, 32'd16, 32'd12345, 32'd10};
        int n;
        logic seen;
        bus4.op = OP_DIVU; bus4.a = da[0]; bus4.b = db[0]; bus4.tag_in = 5'd20; bus4.start = 1'b1;
        sb4.push_back('{da[0] / db[0], 5'd20});
        for (int k = 0; k < 4; k++) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 60) begin
                @(posedge clk); n++;
                @(negedge clk);
                seen = bus4.done;
            end
            check($sformatf("b2b%0d_latency", k), n, (k == 0) ? 10 : 11);
            if (k < 3) begin
                bus4.a = da[k+1]; bus4.b = db[k+1]; bus4.tag_in = 5'(21 + k);
                sb4.push_back('{da[k+1] / db[k+1], 5'(21 + k)});
            end else begin
                bus4.start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus1.start = 0; bus1.op = OP_MUL; bus1.a = 0; bus1.b = 0; bus1.tag_in = 0; bus1.flush = 0;
        bus4.start = 0; bus4.op = OP_MUL; bus4.a = 0; bus4.b = 0; bus4.tag_in = 0; bus4.flush = 0;

        vecs.push_back('{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34});
        vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         32'd14,        34});
        vecs.push_back('{OP_REMU,   32'd100,       32'd7,         32'd2,         34});
        vecs.push_back('{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34});
        vecs.push_back('{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REM,    32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{OP_REMU,   32'd9,         32'd0,         32'd9,         1});
        vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});

        #2;
        check("reset_u1", {bus1.busy, bus1.stall_req, bus1.done, bus1.result, bus1.tag_out}, 0);
        check("reset_u4", {bus4.busy, bus4.stall_req, bus4.done, bus4.result, bus4.tag_out}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            issue1(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Flush in the tenth CALC cycle abandons the operation.
        bus1.start = 1; bus1.op = OP_MUL; bus1.a = 5; bus1.b = 6; bus1.tag_in = 9;
        @(posedge clk); #1 bus1.start = 0;
        repeat (9) @(posedge clk);
        #1 bus1.flush = 1;
        check("flush_pre_busy", bus1.busy, 1);
        @(posedge clk); #1 bus1.flush = 0;
        check("flush_idle", {bus1.busy, bus1.stall_req, bus1.done}, 0);
        @(negedge clk);
        bus1.start = 1; bus1.flush = 1;
        #1 check("flush_blocks_start_stall", bus1.stall_req, 0);
        @(posedge clk); #1 bus1.start = 0; bus1.flush = 0;
        check("flush_blocks_start_busy", bus1.busy, 0);
        @(negedge clk);
        issue1(OP_MUL, 32'd3, 32'd4, 5'd17, 32'd12, 34, "after_flush");

        // Asynchronous reset in the middle of CALC.
        bus1.start = 1; bus1.op = OP_MUL; bus1.a = 100; bus1.b = 200; bus1.tag_in = 11;
        @(posedge clk); #1 bus1.start = 0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_mid_ctrl", {bus1.busy, bus1.stall_req, bus1.done}, 0);
        check("rst_mid_result", bus1.result, 0);
        check("rst_mid_tag", bus1.tag_out, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", {bus1.busy, bus1.done}, 0);
        issue1(OP_DIVU, 32'd100, 32'd7, 5'd30, 32'd14, 34, "after_reset");

        issue4(OP_MUL, 32'd123456, 32'd789, 5'd6, 32'(64'd123456 * 64'd789), 10, "u4_mul");
        issue4(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 10, "u4_mulhu");
        issue4(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 10, "u4_rem");
        run_b2b();

        repeat (4) @(negedge clk);
        check("sb1_drained", sb1.size(), 0);
        check("sb4_drained", sb4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
